// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory-port arbiter.
// Optional performance counters in the top level are enabled by MEM_ARB_PERF_EN.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Encoding doubles as the bit index of each requester in the picker's req vector
  typedef enum logic {
    GNT_INSTR = 1'b0,
    GNT_DATA  = 1'b1
  } grant_e;

  localparam int unsigned MEM_ARB_DEFAULT_TIMEOUT = 64;
  localparam int unsigned PERF_CNT_W              = 32;

  // Saturating increment for the performance counters
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (v == '1) ? v : v + PERF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin picker: on a tie the requester not granted last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  grant_e     last_i,
  output logic       valid_o,
  output grant_e     grant_o
);

  always_comb begin
    valid_o = |req_i;
    grant_o = GNT_INSTR;
    case (req_i)
      2'b10:   grant_o = GNT_DATA;
      2'b01:   grant_o = GNT_INSTR;
      2'b11:   grant_o = (last_i == GNT_DATA) ? GNT_INSTR : GNT_DATA;
      default: grant_o = GNT_INSTR;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the data cache with a busy watchdog.
// Define MEM_ARB_PERF_EN to add saturating grant/contention counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = MEM_ARB_DEFAULT_TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_ack_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic                  i_ack_o,
  output logic [DATA_WIDTH-1:0] i_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  err_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] d_grant_cnt_o,
  output logic [PERF_CNT_W-1:0] i_grant_cnt_o,
  output logic [PERF_CNT_W-1:0] contention_cnt_o
`endif
);

  localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);
  localparam int unsigned WD_W  = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_cmd_t;

  arb_state_e            state_q, state_d;
  grant_e                last_q, last_d;
  grant_e                owner_q, owner_d;
  mem_cmd_t              cmd_q, cmd_d;
  logic                  mem_req_q, mem_req_d;
  logic                  d_ack_q, d_ack_d;
  logic                  i_ack_q, i_ack_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [WD_W-1:0]       wd_q, wd_d;

`ifdef MEM_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] d_cnt_q, d_cnt_d;
  logic [PERF_CNT_W-1:0] i_cnt_q, i_cnt_d;
  logic [PERF_CNT_W-1:0] cont_cnt_q, cont_cnt_d;
`endif

  logic [1:0] req_m;
  logic       gnt_valid;
  grant_e     gnt_sel;

  // A requester is invisible during its own ack cycle so a held req is not served twice
  assign req_m = {d_req_i & ~d_ack_q, i_req_i & ~i_ack_q};

  rr_arb2 u_rr_arb2 (
    .req_i   (req_m),
    .last_i  (last_q),
    .valid_o (gnt_valid),
    .grant_o (gnt_sel)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    cmd_d     = cmd_q;
    mem_req_d = mem_req_q;
    d_ack_d   = 1'b0;
    i_ack_d   = 1'b0;
    err_d     = 1'b0;
    d_rdata_d = d_rdata_q;
    i_rdata_d = i_rdata_q;
    wd_d      = wd_q;
`ifdef MEM_ARB_PERF_EN
    d_cnt_d    = d_cnt_q;
    i_cnt_d    = i_cnt_q;
    cont_cnt_d = cont_cnt_q;
`endif

    case (state_q)
      ARB_IDLE: begin
        if (gnt_valid) begin
          owner_d   = gnt_sel;
          mem_req_d = 1'b1;
          wd_d      = '0;
          state_d   = ARB_BUSY;
          if (gnt_sel == GNT_DATA) begin
            cmd_d.we    = d_we_i;
            cmd_d.addr  = d_addr_i;
            cmd_d.wdata = d_wdata_i;
          end else begin
            cmd_d.we    = 1'b0;
            cmd_d.addr  = i_addr_i;
            cmd_d.wdata = '0;
          end
        end
`ifdef MEM_ARB_PERF_EN
        if (&req_m) cont_cnt_d = sat_inc(cont_cnt_q);
`endif
      end

      ARB_BUSY: begin
        if (mem_ready_i) begin
          mem_req_d = 1'b0;
          last_d    = owner_q;
          state_d   = ARB_IDLE;
          if (owner_q == GNT_DATA) begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_rdata_i;
`ifdef MEM_ARB_PERF_EN
            d_cnt_d   = sat_inc(d_cnt_q);
`endif
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata_i;
`ifdef MEM_ARB_PERF_EN
            i_cnt_d   = sat_inc(i_cnt_q);
`endif
          end
        end else if (WD_EN && (wd_q == WD_LAST)) begin
          // Watchdog abort: ack with error, leave the requester's rdata untouched
          mem_req_d = 1'b0;
          last_d    = owner_q;
          state_d   = ARB_IDLE;
          err_d     = 1'b1;
          if (owner_q == GNT_DATA) d_ack_d = 1'b1;
          else                     i_ack_d = 1'b1;
        end else if (WD_EN) begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ARB_IDLE;
      last_q    <= GNT_INSTR;
      owner_q   <= GNT_INSTR;
      cmd_q     <= '0;
      mem_req_q <= 1'b0;
      d_ack_q   <= 1'b0;
      i_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      d_rdata_q <= '0;
      i_rdata_q <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      cmd_q     <= cmd_d;
      mem_req_q <= mem_req_d;
      d_ack_q   <= d_ack_d;
      i_ack_q   <= i_ack_d;
      err_q     <= err_d;
      d_rdata_q <= d_rdata_d;
      i_rdata_q <= i_rdata_d;
      wd_q      <= wd_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_cnt_q    <= '0;
      i_cnt_q    <= '0;
      cont_cnt_q <= '0;
    end else begin
      d_cnt_q    <= d_cnt_d;
      i_cnt_q    <= i_cnt_d;
      cont_cnt_q <= cont_cnt_d;
    end
  end

  assign d_grant_cnt_o    = d_cnt_q;
  assign i_grant_cnt_o    = i_cnt_q;
  assign contention_cnt_o = cont_cnt_q;
`endif

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = cmd_q.we;
  assign mem_addr_o  = cmd_q.addr;
  assign mem_wdata_o = cmd_q.wdata;
  assign d_ack_o     = d_ack_q;
  assign i_ack_o     = i_ack_q;
  assign err_o       = err_q;
  assign d_rdata_o   = d_rdata_q;
  assign i_rdata_o   = i_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized request pairs
// checked against a latency/round-robin model; watchdog set to 8 cycles.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          d_req_i, d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic          d_ack_o;
  logic [DW-1:0] d_rdata_o;
  logic          i_req_i;
  logic [AW-1:0] i_addr_i;
  logic          i_ack_o;
  logic [DW-1:0] i_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ready_i;
  logic [DW-1:0] mem_rdata_i;
  logic          err_o;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   d_grant_cnt_o, i_grant_cnt_o, contention_cnt_o;
`endif

  mem_port_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_ack_o     (d_ack_o),
    .d_rdata_o   (d_rdata_o),
    .i_req_i     (i_req_i),
    .i_addr_i    (i_addr_i),
    .i_ack_o     (i_ack_o),
    .i_rdata_o   (i_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i),
    .err_o       (err_o)
`ifdef MEM_ARB_PERF_EN
    ,
    .d_grant_cnt_o    (d_grant_cnt_o),
    .i_grant_cnt_o    (i_grant_cnt_o),
    .contention_cnt_o (contention_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model state: who was granted last (reset: instruction), expected held rdata
  bit          last_d = 1'b0;
  logic [31:0] exp_d_rdata = '0;
  logic [31:0] exp_i_rdata = '0;

  // Memory model controls
  int unsigned mem_k = 0;
  bit          mem_hang = 1'b0;
  bit          stray_ready = 1'b0;
  int unsigned busy_cnt = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responds k cycles after it first sees mem_req_o; data depends only on address
  initial begin
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (mem_req_o && !mem_hang) begin
        if (busy_cnt == mem_k) begin
          mem_ready_i = 1'b1;
          mem_rdata_i = mem_fn(mem_addr_o);
          busy_cnt    = 0;
        end else begin
          mem_ready_i = 1'b0;
          busy_cnt++;
        end
      end else begin
        mem_ready_i = stray_ready;
        mem_rdata_i = 32'hBAD0_BAD0;
        busy_cnt    = 0;
      end
    end
  end

  // Walk to the predicted ack cycle checking the memory command, then check the ack itself
  task automatic expect_txn(input bit is_d, input int unsigned exp_cyc,
                            input int unsigned exp_req_cycles, input bit exp_err,
                            input string tag);
    logic        we_e;
    logic [31:0] addr_e, wd_e;
    int unsigned req_cycles = 0;
    bit          early = 1'b0;
    we_e   = is_d ? d_we_i : 1'b0;
    addr_e = is_d ? d_addr_i : i_addr_i;
    wd_e   = d_wdata_i;
    while (cyc < exp_cyc) begin
      @(negedge clk_i);
      if (mem_req_o) begin
        req_cycles++;
        chk({tag, ".mem_addr"}, mem_addr_o, addr_e);
        chk({tag, ".mem_we"}, 32'(mem_we_o), 32'(we_e));
        if (we_e) chk({tag, ".mem_wdata"}, mem_wdata_o, wd_e);
      end
      if (cyc < exp_cyc && (d_ack_o || i_ack_o || err_o)) early = 1'b1;
    end
    chk({tag, ".early_ack"}, 32'(early), 32'd0);
    chk({tag, ".req_cycles"}, req_cycles, exp_req_cycles);
    chk({tag, ".d_ack"}, 32'(d_ack_o), 32'(is_d));
    chk({tag, ".i_ack"}, 32'(i_ack_o), 32'(!is_d));
    chk({tag, ".err"}, 32'(err_o), 32'(exp_err));
    if (!exp_err) begin
      if (is_d) exp_d_rdata = mem_fn(addr_e);
      else      exp_i_rdata = mem_fn(addr_e);
    end
    chk({tag, ".d_rdata"}, d_rdata_o, exp_d_rdata);
    chk({tag, ".i_rdata"}, i_rdata_o, exp_i_rdata);
    last_d = is_d;
  endtask

  // Requesters raise req together and drop it in their own ack cycle
  task automatic run_pair(input bit dv, input bit iv, input int unsigned k, input string tag);
    bit first;
    mem_k   = k;
    d_req_i = dv;
    i_req_i = iv;
    first   = (dv && iv) ? !last_d : dv;
    expect_txn(first, cyc + 2 + k, k + 1, 1'b0, tag);
    if (first) d_req_i = 1'b0; else i_req_i = 1'b0;
    if (dv && iv) begin
      expect_txn(!first, cyc + 2 + k, k + 1, 1'b0, tag);
      if (!first) d_req_i = 1'b0; else i_req_i = 1'b0;
    end
    @(negedge clk_i);
    chk({tag, ".no_regrant"}, 32'(mem_req_o), 32'd0);
    chk({tag, ".no_extra_ack"}, 32'(d_ack_o | i_ack_o), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_req"}, 32'(mem_req_o), 32'd0);
    chk({tag, ".mem_we"}, 32'(mem_we_o), 32'd0);
    chk({tag, ".mem_addr"}, mem_addr_o, 32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata_o, 32'd0);
    chk({tag, ".acks"}, 32'({d_ack_o, i_ack_o, err_o}), 32'd0);
    chk({tag, ".d_rdata"}, d_rdata_o, 32'd0);
    chk({tag, ".i_rdata"}, i_rdata_o, 32'd0);
  endtask

  initial begin
    bit          nxt;
    bit          seen;
    int unsigned mode, k;
    rst_i = 1'b1;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
    i_req_i = 1'b0; i_addr_i = '0;
    repeat (3) @(negedge clk_i);
    chk_all_zero("reset");
    rst_i = 1'b0;

    // Tie right after reset: data first, then instruction
    d_we_i = 1'b0; d_addr_i = 32'h0000_1000; i_addr_i = 32'h0000_2000;
    run_pair(1'b1, 1'b1, 1, "tie_after_reset");

    // Single data read, memory ready immediately
    d_addr_i = 32'h0000_0040;
    run_pair(1'b1, 1'b0, 0, "d_read_k0");

    // Data write with 3 wait cycles
    d_we_i = 1'b1; d_addr_i = 32'h0000_0400; d_wdata_i = 32'hDEAD_BEEF;
    run_pair(1'b1, 1'b0, 3, "d_write_k3");
    d_we_i = 1'b0;

    // Both held across six transactions: strict alternation
    mem_k = 1; d_addr_i = 32'h0000_3000; i_addr_i = 32'h0000_4000;
    d_req_i = 1'b1; i_req_i = 1'b1;
    nxt = !last_d;
    for (int t = 0; t < 6; t++) begin
      expect_txn(nxt, cyc + 3, 2, 1'b0, "alternate");
      nxt = !nxt;
    end
    d_req_i = 1'b0; i_req_i = 1'b0;
    @(negedge clk_i);
    chk("alternate.idle", 32'(mem_req_o), 32'd0);

    // Ready pulsing while idle must do nothing
    stray_ready = 1'b1;
    repeat (2) begin
      @(negedge clk_i);
      chk("stray_ready", 32'({mem_req_o, d_ack_o, i_ack_o, err_o}), 32'd0);
    end
    stray_ready = 1'b0;
    @(negedge clk_i);

    // Watchdog abort on an instruction fetch, then normal service resumes
    mem_hang = 1'b1;
    i_addr_i = 32'h0000_5000;
    i_req_i  = 1'b1;
    expect_txn(1'b0, cyc + 1 + TO, TO, 1'b1, "timeout");
    i_req_i = 1'b0;
    @(negedge clk_i);
    chk("timeout.mem_req_dropped", 32'(mem_req_o), 32'd0);
    mem_hang = 1'b0;
    i_addr_i = 32'h0000_5004;
    run_pair(1'b0, 1'b1, 2, "after_timeout");

    // Reset in the middle of a busy transaction: no ack, everything cleared
    mem_k = 5; d_addr_i = 32'h0000_6000; d_req_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_busy.mem_req_before", 32'(mem_req_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk_all_zero("rst_busy");
`ifdef MEM_ARB_PERF_EN
    chk("perf.d_cnt", d_grant_cnt_o, 32'd0);
    chk("perf.i_cnt", i_grant_cnt_o, 32'd0);
    chk("perf.cont_cnt", contention_cnt_o, 32'd0);
`endif
    rst_i = 1'b0; d_req_i = 1'b0;
    last_d = 1'b0; exp_d_rdata = '0; exp_i_rdata = '0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      if (mem_req_o || d_ack_o || i_ack_o) seen = 1'b1;
    end
    chk("rst_busy.discarded", 32'(seen), 32'd0);

    // Randomized request pairs against the latency/round-robin model
    for (int n = 0; n < 20; n++) begin
      mode      = $urandom_range(1, 3);
      k         = $urandom_range(0, 4);
      d_we_i    = 1'($urandom_range(0, 1));
      d_addr_i  = $urandom;
      d_wdata_i = $urandom;
      i_addr_i  = $urandom;
      run_pair(mode[1], mode[0], k, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
